// File: rtl/counter_pkg.sv
// Shared encodings for the 4-bit counter stage and its downstream event logger.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_UP3  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        EV_RCO  = 2'b01,
        EV_LOAD = 2'b10,
        EV_BOTH = 2'b11
    } ev_type_e;

    localparam int EV_W = 8;
    localparam int HI_W = 12;

    // Only meaningful when at least one of load/rco is set.
    function automatic ev_type_e ev_type(input logic load, input logic rco);
        return ev_type_e'({load, rco});
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with a registered head output; the head is valid whenever
// o_empty is low. The caller must not push into a full FIFO without a pop.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_data;
    logic [AW-1:0]    w_rd_next;

    assign w_rd_next = r_rd_ptr + AW'(1);
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_data    = r_data;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
            // Head register: next stored entry on pop, or bypass the push into an emptying FIFO.
            if (i_pop) begin
                if (r_count > (AW+1)'(1)) begin
                    r_data <= r_mem[w_rd_next];
                end else if (i_push) begin
                    r_data <= i_data;
                end
            end else if (i_push && o_empty) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/rco_event_logger.sv
// Extends the counter's Q with a 12-bit RCO-driven high part and queues RCO/LOAD
// events. Optional RCO consistency check is enabled by defining RCO_CHECK_EN.
module rco_event_logger
    import counter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ENABLE,
    input  logic [1:0]      MODO,
    input  logic [3:0]      Q,
    input  logic            RCO,
    input  logic            LOAD,
    output logic [15:0]     Q_EXT,
    output logic [EV_W-1:0] EV_DATA,
    output logic            EV_VALID,
    input  logic            EV_READY,
    output logic [3:0]      OVF_CNT,
    output logic            ERR
);
    logic [HI_W-1:0] r_hi;
    logic [3:0]      r_ovf;
    logic            w_event;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_full;
    logic            w_empty;
    logic [EV_W-1:0] w_record;

    assign w_event  = ENABLE & (RCO | LOAD);
    assign w_pop    = EV_VALID & EV_READY;
    assign w_push   = w_event & (~w_full | w_pop);
    assign w_drop   = w_event & w_full & ~w_pop;
    assign w_record = {ev_type(LOAD, RCO), MODO, Q};
    assign EV_VALID = ~w_empty;
    assign Q_EXT    = {r_hi, Q};
    assign OVF_CNT  = r_ovf;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_hi <= '0;
        end else if (ENABLE) begin
            if (LOAD) begin
                r_hi <= '0;
            end else if (RCO) begin
                case (MODO)
                    MODE_UP, MODE_UP3: r_hi <= r_hi + HI_W'(1);
                    MODE_DOWN:         r_hi <= r_hi - HI_W'(1);
                    default:           r_hi <= r_hi;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ovf <= '0;
        end else if (w_drop && (r_ovf != 4'hF)) begin
            r_ovf <= r_ovf + 4'd1;
        end
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET),
        .i_push  (w_push),
        .i_data  (w_record),
        .i_pop   (w_pop),
        .o_data  (EV_DATA),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

`ifdef RCO_CHECK_EN
    logic w_rco_bad;
    logic r_err;

    always_comb begin
        w_rco_bad = 1'b0;
        if (ENABLE && RCO && !LOAD) begin
            case (MODO)
                MODE_UP:   w_rco_bad = (Q != 4'hF);
                MODE_DOWN: w_rco_bad = (Q != 4'h0);
                MODE_UP3:  w_rco_bad = (Q < 4'hD);
                default:   w_rco_bad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_err <= 1'b0;
        end else if (w_rco_bad) begin
            r_err <= 1'b1;
        end
    end

    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_rco_event_logger.sv
// Randomised bench for rco_event_logger with a queue-based reference model.
module tb_rco_event_logger;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        ENABLE = 1'b0;
    logic [1:0]  MODO = 2'b00;
    logic [3:0]  Q = 4'h5;
    logic        RCO = 1'b0;
    logic        LOAD = 1'b0;
    logic        EV_READY = 1'b0;
    logic [15:0] Q_EXT;
    logic [7:0]  EV_DATA;
    logic        EV_VALID;
    logic [3:0]  OVF_CNT;
    logic        ERR;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 1'b0;

    int         m_hi;
    logic [7:0] m_q[$];
    int         m_ovf;
    bit         m_err;

    rco_event_logger #(.DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .MODO     (MODO),
        .Q        (Q),
        .RCO      (RCO),
        .LOAD     (LOAD),
        .Q_EXT    (Q_EXT),
        .EV_DATA  (EV_DATA),
        .EV_VALID (EV_VALID),
        .EV_READY (EV_READY),
        .OVF_CNT  (OVF_CNT),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = 0;
        m_q.delete();
        m_ovf = 0;
        m_err = 1'b0;
    endtask

    // One clock edge of the specified behaviour, from the inputs sampled at that edge.
    task automatic model_step();
        bit pop;
        bit ev;
        if (!RESET) begin
            model_reset();
            return;
        end
        pop = (m_q.size() > 0) && EV_READY;
        ev  = ENABLE && (RCO || LOAD);
        if (ENABLE) begin
            if (LOAD) m_hi = 0;
            else if (RCO && (MODO == 2'd0 || MODO == 2'd2)) m_hi = (m_hi + 1) % 4096;
            else if (RCO && MODO == 2'd1) m_hi = (m_hi + 4095) % 4096;
        end
`ifdef RCO_CHECK_EN
        if (ENABLE && RCO && !LOAD) begin
            if ((MODO == 2'd0 && Q != 4'hF) || (MODO == 2'd1 && Q != 4'h0) ||
                (MODO == 2'd2 && Q < 4'hD))
                m_err = 1'b1;
        end
`endif
        if (pop) void'(m_q.pop_front());
        if (ev) begin
            if (m_q.size() < DEPTH) m_q.push_back({LOAD, RCO, MODO, Q});
            else if (m_ovf < 15) m_ovf = m_ovf + 1;
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        #1;
    endtask

    task automatic drive(input bit en, input logic [1:0] md, input logic [3:0] q,
                         input bit rco, input bit load, input bit rdy);
        ENABLE = en; MODO = md; Q = q; RCO = rco; LOAD = load; EV_READY = rdy;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && m_q.size() > 0; k++) begin
            drive(1, 2'd0, Q, 0, 0, 1);
            cyc();
        end
        check("drain_empty", 32'(EV_VALID), 32'd0);
    endtask

    // Compare process: every cycle outside reset, DUT against model.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_on && RESET) begin
                check("q_ext", 32'(Q_EXT), 32'({m_hi[11:0], Q}));
                check("ev_valid", 32'(EV_VALID), 32'(m_q.size() > 0));
                if (m_q.size() > 0) check("ev_data", 32'(EV_DATA), 32'(m_q[0]));
                check("ovf_cnt", 32'(OVF_CNT), 32'(m_ovf));
                check("err", 32'(ERR), 32'(m_err));
            end
        end
    end

    initial begin
        int valid_cycles;
        model_reset();
        drive(0, 2'd0, 4'h5, 1, 0, 0);
        #12;
        check("rst_q_ext", 32'(Q_EXT), 32'h0005);
        check("rst_valid", 32'(EV_VALID), 32'd0);
        check("rst_data", 32'(EV_DATA), 32'd0);
        check("rst_ovf", 32'(OVF_CNT), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        @(negedge CLK); #1;
        RESET = 1'b1;
        chk_on = 1'b1;
        cyc(); cyc();
        check("dis_q_ext", 32'(Q_EXT), 32'h0005);
        check("dis_valid", 32'(EV_VALID), 32'd0);
        $display("scenario enable-low rco: q_ext=%h", Q_EXT);

        drive(1, 2'd0, 4'hF, 1, 0, 1);
        cyc();
        check("up_first_rec", 32'(EV_DATA), 32'h4F);
        for (int i = 1; i < 17; i++) cyc();
        check("up17_q_ext", 32'(Q_EXT), 32'h011F);
        drive(1, 2'd0, 4'h3, 0, 1, 1);
        cyc();
        check("load_q_ext", 32'(Q_EXT), 32'h0003);
        check("load_rec", 32'(EV_DATA), 32'h83);
        $display("scenario up17+load: q_ext=%h rec=%h", Q_EXT, EV_DATA);

        drive(1, 2'd1, 4'h0, 1, 0, 1);
        cyc();
        check("down_wrap", 32'(Q_EXT), 32'hFFF0);
        drive(1, 2'd1, 4'h0, 0, 0, 1);
        cyc();
        $display("scenario down wrap: q_ext=%h", Q_EXT);

        drain();
        for (int i = 0; i < 6; i++) begin
            drive(1, 2'd3, 4'(i), 1, 0, 0);
            cyc();
        end
        drive(1, 2'd3, 4'h0, 0, 0, 0);
        cyc(); cyc();
        check("full_ovf", 32'(OVF_CNT), 32'd2);
        check("full_head", 32'(EV_DATA), 32'h70);
        check("full_model_occ", 32'(m_q.size()), 32'd4);
        drive(1, 2'd3, 4'h9, 1, 0, 1);
        cyc();
        check("pushpop_ovf", 32'(OVF_CNT), 32'd2);
        check("pushpop_head", 32'(EV_DATA), 32'h71);
        valid_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 2'd3, 4'h0, 0, 0, 1);
            if (EV_VALID) valid_cycles++;
            cyc();
        end
        check("pushpop_occ", 32'(valid_cycles), 32'd4);
        $display("scenario full fifo: ovf=%0d drained=%0d", OVF_CNT, valid_cycles);

        drive(1, 2'd0, 4'h2, 1, 1, 1);
        cyc();
        check("both_rec", 32'(EV_DATA), 32'hC2);
        check("both_q_ext", 32'(Q_EXT), 32'h0002);
        drive(1, 2'd0, 4'h2, 0, 0, 1);
        cyc();
        $display("scenario rco+load: rec=%h", EV_DATA);

        drive(1, 2'd0, 4'h7, 1, 0, 0);
        cyc();
        drive(1, 2'd0, 4'h7, 0, 0, 0);
        cyc(); cyc(); cyc();
`ifdef RCO_CHECK_EN
        check("err_set", 32'(ERR), 32'd1);
`else
        check("err_tied", 32'(ERR), 32'd0);
`endif
        RESET = 1'b0;
        model_reset();
        #1;
        check("midrst_err", 32'(ERR), 32'd0);
        check("midrst_valid", 32'(EV_VALID), 32'd0);
        check("midrst_data", 32'(EV_DATA), 32'd0);
        check("midrst_q_ext", 32'(Q_EXT), 32'h0007);
        cyc();
        RESET = 1'b1;
        $display("scenario rco check + reset: err=%0d", ERR);

        for (int i = 0; i < 3000; i++) begin
            bit lazy;
            lazy = ((i / 300) % 2) == 1;
            drive(($urandom % 4) != 0, 2'($urandom), 4'($urandom), ($urandom % 3) == 0,
                  ($urandom % 5) == 0, lazy ? (($urandom % 6) == 0) : (($urandom % 4) != 0));
            if (i == 1500) begin
                RESET = 1'b0;
                model_reset();
                cyc();
                RESET = 1'b1;
            end
            cyc();
        end
        $display("scenario random: ovf=%0d hi=%h", OVF_CNT, Q_EXT[15:4]);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rco_event_logger.md
# rco_event_logger

Downstream consumer of the 4-bit `counter` stage. It samples `Q`, `RCO`, `LOAD` and `MODO` every `CLK` edge and maintains a 16-bit cascaded count by extending `Q` with a 12-bit high part driven by `RCO`. It also queues each `RCO`/`LOAD` event as an 8-bit record into a small FIFO drained through a valid/ready port, so the checker and logging logic can consume counter activity without tracking it cycle by cycle.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `ENABLE` in 1: same enable that drives the counter; events are ignored while low.
- `MODO` in 2: counter mode. 00 = up 1, 01 = down 1, 10 = up 3, 11 = load `D`.
- `Q` in 4: counter output.
- `RCO` in 1: counter ripple carry.
- `LOAD` in 1: counter load indication.
- `Q_EXT` out 16: `{HI[11:0], Q}`.
- `EV_DATA` out 8: head record `{TYPE[1:0], MODO[1:0], Q[3:0]}`.
- `EV_VALID` out 1: FIFO non-empty.
- `EV_READY` in 1: consumer accepts the head record.
- `OVF_CNT` out 4: dropped-event count; saturates at 15.
- `ERR` out 1: sticky RCO-consistency error (see Configuration).

## Operation
- Event at an edge: `ENABLE & (RCO | LOAD)`.
- `TYPE` encoding:
  - 01 = `RCO` only.
  - 10 = `LOAD` only.
  - 11 = both in the same cycle.
  - 00 is never produced.
- HI update at an edge with `ENABLE` high:
  - `LOAD`: HI <= 0. `LOAD` has priority over `RCO`.
  - `RCO` with `MODO` 00 or 10: HI <= HI+1.
  - `RCO` with `MODO` 01: HI <= HI-1.
  - `RCO` with `MODO` 11 and no `LOAD`: HI unchanged.
  - All HI arithmetic is modulo 4096. FFF+1 gives 000; 000-1 gives FFF.
- FIFO push: one push per event. The record captures the `MODO` and `Q` values sampled at that edge.
- FIFO pop: on an edge where `EV_VALID & EV_READY`.
- Full FIFO:
  - An event with no pop in the same cycle is dropped and increments `OVF_CNT` (saturating).
  - A simultaneous push and pop when full: both are accepted, occupancy stays at `DEPTH`, and nothing is dropped.
- Simultaneous push and pop when empty is impossible, because `EV_VALID` is low.
- While `ENABLE` is low, `EV_READY` pops are still honoured; the drain is independent of `ENABLE`.

## Timing
- Reset values, forced immediately when `RESET` is low, regardless of `CLK`:
  - HI = 0, so `Q_EXT` = {12'h000, `Q`}.
  - FIFO empty, `EV_VALID` = 0, `EV_DATA` = 0.
  - `OVF_CNT` = 0, `ERR` = 0.
- Reset asserted mid-operation discards all queued records.
- HI latency: updated at the same edge where `RCO`/`LOAD` is sampled, so `Q_EXT` reflects it one cycle later.
- Push to `EV_VALID` latency: 1 cycle. A record pushed at edge n is visible at the head after edge n.
- `EV_DATA` is registered from the head entry. While `EV_VALID & !EV_READY` it must stay stable.
- Full throughput: one push and one pop per cycle is sustained indefinitely.

## Configuration
- Macro: `RCO_CHECK_EN`.
- Defined: at each edge with `ENABLE & RCO & !LOAD`, `ERR` is set and held until reset if either:
  - `MODO`=00 and `Q`≠4'hF, or
  - `MODO`=01 and `Q`≠4'h0, or
  - `MODO`=10 and `Q`<4'hD.
- Not defined: `ERR` is tied to 0 and no check logic is synthesised.

## Structure
- Shared package `counter_pkg`:
  - `MODO` encodings: `MODE_UP`, `MODE_DOWN`, `MODE_UP3`, `MODE_LOAD`.
  - `TYPE` codes: `EV_RCO`, `EV_LOAD`, `EV_BOTH`.
  - `EV_W` = 8.
  - HI width = 12.
- Sub-module `event_fifo`: parameterised synchronous FIFO with `DEPTH`/width parameters and push/pop/full/empty ports, instantiated once. HI, overflow and check logic stay in the top level.

## Test plan
- Reset with `Q`=4'h5, then hold `ENABLE`=0 and pulse `RCO`: `Q_EXT`=16'h0005, `EV_VALID`=0, `OVF_CNT`=0.
- `MODO`=00, 17 `RCO` pulses, then `LOAD`, with `EV_READY`=1:
  - HI reaches 16'h011, then returns to 0 on `LOAD`.
  - Records arrive in order: 8'h4F repeated (01_00_1111), then the `LOAD` record 8'h8x.
- `MODO`=01 from HI=0, one `RCO` with `Q`=0: HI=12'hFFF, `Q_EXT`=16'hFFF0.
- `EV_READY`=0 with 6 events at `DEPTH`=4:
  - 4 records are queued and `OVF_CNT`=2.
  - `EV_DATA` holds the first record stable.
  - A push and pop in the same cycle while full leaves occupancy at 4 and `OVF_CNT` at 2.
- `RCO` and `LOAD` together: record `TYPE`=2'b11 and HI=0.
- `RCO_CHECK_EN` defined, `MODO`=00, `RCO` with `Q`=4'h7: `ERR`=1 and held until `RESET` is low; without the macro, `ERR`=0.
